alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 issue_valid  input  1  operation presented this cycle.
REQ-004 alu_contr  input  4  operation code (encoding REQ-010).
REQ-005 a, b  input  32 each  operands; signed where the operation is signed.
REQ-006 result  output  32  registered result of a single-cycle operation.
REQ-007 zero  output  1  registered; 1 when result == 0.
REQ-008 result_valid  output  1  one-cycle pulse qualifying result and zero.
REQ-009 busy  output  1  divide in progress; upstream stalls while high.

Function
REQ-010 Codes: 0000 AND, 0001 OR, 0010 ADD, 1010 ADDI (same as ADD), 0110 SUB, 0111 SLT (signed; result 1 or 0), 1100 NOR, 0011 MFHI, 0100 MFLO, 1000 MULT, 1001 DIV, 1111 JUMP (result 0); 0101, 1011, 1101, 1110 are unused (result 0).
REQ-011 An operation is accepted only when issue_valid=1 and busy=0; issue_valid while busy=1 is ignored, with no state change.
REQ-012 Accepted single-cycle operations (all except MULT and DIV) update result and zero, and pulse result_valid, at the next rising edge (latency 1).
REQ-013 ADD and SUB wrap modulo 2^32; no overflow detection and no trap.
REQ-014 MFHI and MFLO return HI and LO as registered at the accept edge, so a MULT accepted at cycle T is visible to an MFHI accepted at T+1.
REQ-015 MULT: signed 32x32 -> 64 product; HI = bits [63:32] and LO = bits [31:0], written at the next edge; no result_valid pulse; busy stays 0.
REQ-016 DIV: signed, iterative restoring division on operand magnitudes, one quotient bit per cycle.
REQ-017 DIV FSM states:
- IDLE -> RUN on an accepted DIV (operands latched, count = 0).
- RUN: count increments each cycle; RUN -> FIX after 32 iterations.
- FIX: sign correction, HI/LO written, FIX -> IDLE.
REQ-018 DIV accepted at cycle T: busy is high in cycles T+1 .. T+33; HI/LO hold the new values from T+34; no result_valid pulse.
REQ-019 Quotient sign = sign(a) XOR sign(b); remainder takes the sign of a.
REQ-020 Divide by zero: LO = 0xFFFFFFFF and HI = a; same latency as REQ-018.
REQ-021 Divide overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
REQ-022 result, zero and result_valid are not affected while a divide runs; result_valid = 0 in every cycle without an accepted single-cycle operation.

Reset
REQ-023 With rst=1 at an edge: result = 0, zero = 1, result_valid = 0, busy = 0, HI = 0, LO = 0, FSM = IDLE, count = 0.
REQ-024 rst during RUN or FIX aborts the divide: HI/LO = 0, and no partial value is ever written.

Configuration
REQ-025 Macro ALU_DIV_EN.
- Defined: divider present; behaviour per REQ-016..REQ-021.
- Undefined: no divider logic and no FSM; busy tied to 0; an accepted DIV is a no-op (HI/LO unchanged, no result_valid pulse).

Structure
REQ-026 Package alu_pkg holds the 4-bit opcode constants, the DIV FSM state typedef (IDLE, RUN, FIX), and the data width constant (32).
REQ-027 Sub-module alu_divider contains the FSM, the counter and the restoring datapath, with a start/done handshake; it is instantiated only under ALU_DIV_EN.

Verification
REQ-028 ADD a=0x7FFFFFFF, b=1 -> next cycle result=0x80000000, zero=0, result_valid=1; SUB a=5, b=5 -> result=0, zero=1.
REQ-029 SLT a=0xFFFFFFFF, b=1 -> result=1; NOR a=0, b=0 -> result=0xFFFFFFFF; code 1101 -> result=0, result_valid=1.
REQ-030 MULT a=-3, b=7 then MFLO next cycle -> result=0xFFFFFFEB; MFHI -> result=0xFFFFFFFF.
REQ-031 DIV a=-7, b=2 at T -> busy high T+1..T+33, issues ignored meanwhile; MFLO at T+34 -> 0xFFFFFFFD; MFHI -> 0xFFFFFFFF.
REQ-032 DIV a=9, b=0 -> LO=0xFFFFFFFF, HI=9; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 rst at T+10 of a DIV -> busy=0 next cycle, MFHI and MFLO both return 0; with ALU_DIV_EN undefined, DIV leaves HI/LO unchanged and busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, data width and divider state type for the ALU execute slice.
// Divider support is selected in alu_exec by the ALU_DIV_EN macro.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MFHI = 4'b0011;
  localparam logic [3:0] OP_MFLO = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_JUMP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Signed iterative restoring divider: one quotient bit per cycle, sign fix-up in FIX.
// Only instantiated by alu_exec when ALU_DIV_EN is defined.
module alu_divider
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  div_state_e        state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
  logic              neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
  logic [DATA_W:0]   rem_sh, diff;
  logic              take;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (count_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift the next dividend bit into the partial remainder and subtract when it fits.
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign take   = (rem_sh >= {1'b0, dvs_q});

  always_comb begin
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    if (state_q == IDLE && start_i) begin
      count_d = '0;
      rem_d   = '0;
      quo_d   = magnitude(a_i);
      dvs_d   = magnitude(b_i);
      a_d     = a_i;
      neg_q_d = a_i[DATA_W-1] ^ b_i[DATA_W-1];
      neg_r_d = a_i[DATA_W-1];
      dz_d    = (b_i == '0);
    end else if (state_q == RUN) begin
      count_d = count_q + 5'd1;
      rem_d   = take ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      quo_d   = {quo_q[DATA_W-2:0], take};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == FIX);
    lo_o   = neg_q_q ? (~quo_q + 1'b1) : quo_q;
    hi_o   = neg_r_q ? (~rem_q + 1'b1) : rem_q;
    if (dz_q) begin
      lo_o = '1;
      hi_o = a_q;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle ops with registered result, MULT/DIV into HI/LO.
// Define ALU_DIV_EN to include the iterative divider; otherwise DIV is a no-op.
module alu_exec
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [3:0]        alu_contr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              result_valid,
  output logic              busy
);

  logic [DATA_W-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d, alu_out;
  logic                zero_q, zero_d, valid_q, valid_d;
  logic                accept, single;
  logic signed [63:0]  prod;

`ifdef ALU_DIV_EN
  logic              div_done;
  logic [DATA_W-1:0] div_hi, div_lo;

  alu_divider u_div (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (accept && (alu_contr == OP_DIV)),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (div_done),
    .hi_o    (div_hi),
    .lo_o    (div_lo)
  );
`else
  assign busy = 1'b0;
`endif

  assign accept = issue_valid && !busy;
  assign single = accept && (alu_contr != OP_MULT) && (alu_contr != OP_DIV);
  assign prod   = $signed(a) * $signed(b);

  always_comb begin
    alu_out = '0;
    unique case (alu_contr)
      OP_AND:          alu_out = a & b;
      OP_OR:           alu_out = a | b;
      OP_ADD, OP_ADDI: alu_out = a + b;
      OP_SUB:          alu_out = a - b;
      OP_SLT:          alu_out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:          alu_out = ~(a | b);
      OP_MFHI:         alu_out = hi_q;
      OP_MFLO:         alu_out = lo_q;
      default:         alu_out = '0;
    endcase
  end

  always_comb begin
    result_d = single ? alu_out : result_q;
    zero_d   = single ? (alu_out == '0) : zero_q;
    valid_d  = single;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept && alu_contr == OP_MULT) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end
`ifdef ALU_DIV_EN
    else if (div_done) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign result       = result_q;
  assign zero         = zero_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec; DIV checks follow the ALU_DIV_EN build setting.
module tb_alu_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [3:0]  alu_contr = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        zero, result_valid, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  alu_exec dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .alu_contr    (alu_contr),
    .a            (a),
    .b            (b),
    .result       (result),
    .zero         (zero),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && result_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_valid actual=%b result=%h required=no_pulse", result_valid, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'b0, zero}, {31'b0, (e.res == 32'h0)});
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input logic [31:0] res);
    issue_valid = 1'b1;
    alu_contr   = op;
    a           = x;
    b           = y;
    if (push) sb.push_back('{res, cyc + 1});
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

`ifdef ALU_DIV_EN
  task automatic div_run(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] lo_e, input logic [31:0] hi_e);
    int hi_cnt = 0;
    issue(OP_DIV, x, y, 1'b0, '0);
    for (int i = 0; i < 33; i++) begin
      if (busy === 1'b1) hi_cnt++;
      issue_valid = 1'b1;
      alu_contr   = OP_ADD;
      a           = 32'd1;
      b           = 32'd1;
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;
    chk("div_busy_cycles", hi_cnt, 33);
    chk("div_busy_release", {31'b0, busy}, 32'h0);
    issue(OP_MFLO, '0, '0, 1'b1, lo_e);
    issue(OP_MFHI, '0, '0, 1'b1, hi_e);
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_result", result, 32'h0);
    chk("reset_zero", {31'b0, zero}, 32'h1);
    chk("reset_valid", {31'b0, result_valid}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    mon_en = 1'b1;

    issue(OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 32'h00F0_000F);
    issue(OP_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, 32'hFFF0_0FFF);
    issue(OP_ADD,  32'h7FFF_FFFF, 32'h1,         1'b1, 32'h8000_0000);
    issue(OP_ADDI, 32'h10,        32'h20,        1'b1, 32'h30);
    issue(OP_SUB,  32'd5,         32'd5,         1'b1, 32'h0);
    issue(OP_SUB,  32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'h1,         1'b1, 32'h1);
    issue(OP_SLT,  32'h1,         32'hFFFF_FFFF, 1'b1, 32'h0);
    issue(OP_NOR,  32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF);
    issue(4'b1101, 32'h1234,      32'h5678,      1'b1, 32'h0);
    issue(OP_JUMP, 32'hFFFF,      32'h1,         1'b1, 32'h0);
    issue(4'b0101, 32'hAAAA,      32'h5555,      1'b1, 32'h0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, '0);
    chk("mult_busy", {31'b0, busy}, 32'h0);
    issue(OP_MFLO, '0, '0, 1'b1, 32'hFFFF_FFEB);
    issue(OP_MFHI, '0, '0, 1'b1, 32'hFFFF_FFFF);

`ifdef ALU_DIV_EN
    div_run(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    div_run(32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
    div_run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    div_run(32'd100, 32'd7, 32'd14, 32'd2);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, '0);
    issue(OP_DIV, 32'd100, 32'd7, 1'b0, '0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_result", result, 32'h0);
    issue(OP_MFHI, '0, '0, 1'b1, 32'h0);
    issue(OP_MFLO, '0, '0, 1'b1, 32'h0);
`else
    issue(OP_DIV, 32'd9, 32'd0, 1'b0, '0);
    chk("nodiv_busy", {31'b0, busy}, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk("nodiv_busy_later", {31'b0, busy}, 32'h0);
    issue(OP_MFHI, '0, '0, 1'b1, 32'hFFFF_FFFF);
    issue(OP_MFLO, '0, '0, 1'b1, 32'hFFFF_FFEB);
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
